// File: rtl/frame_link_engine_if.sv
// -----------------------------------------------------------------------------
// frame_link_engine_if
// Byte-level strobe interface between the frame link engine and the existing
// UART TX/RX cores.
//   tx_byte_data   engine -> UART TX : byte to transmit
//   tx_byte_start  engine -> UART TX : one-cycle start strobe
//   tx_byte_done   UART TX -> engine : one-cycle byte-finished pulse
//   rx_byte_valid  UART RX -> engine : one-cycle received-byte pulse
//   rx_byte_data   UART RX -> engine : received byte, valid with rx_byte_valid
// master = engine side, slave = UART side.
// -----------------------------------------------------------------------------
interface frame_link_engine_if;
    logic [7:0] tx_byte_data;
    logic       tx_byte_start;
    logic       tx_byte_done;
    logic       rx_byte_valid;
    logic [7:0] rx_byte_data;

    modport master (
        output tx_byte_data,
        output tx_byte_start,
        input  tx_byte_done,
        input  rx_byte_valid,
        input  rx_byte_data
    );

    modport slave (
        input  tx_byte_data,
        input  tx_byte_start,
        output tx_byte_done,
        output rx_byte_valid,
        output rx_byte_data
    );
endinterface

// File: rtl/frame_link_engine.sv
// -----------------------------------------------------------------------------
// frame_link_engine
// Frame-level UART link engine. Sends a TX_BYTES-byte frame byte by byte to the
// UART TX core (with GAP_CYC idle cycles before every byte) and assembles
// RX_BYTES-byte frames (SOF0, SOF1, payload, additive checksum) from the UART
// RX core, with SOF hunt/resync and an inter-byte timeout.
//
// Ports:
//   clk, reset_n          clock, asynchronous active-low reset
//   tx_frame_start_i      send request, honoured only while not busy
//   tx_frame_i            frame to send, byte 0 in bits [7:0] goes first
//   tx_busy_o             frame in transmission
//   tx_frame_sent_o       pulse when the last byte has completed
//   rx_frame_o            last good frame (byte 0 = SOF0)
//   rx_frame_done_o       pulse on good frame
//   check_sum_error_o     pulse on checksum mismatch
//   com_no_response_o     pulse on inter-byte timeout
//   rx_err_cnt_o          saturating count of checksum errors + timeouts
//   byte_if               byte strobe handshakes to the UART cores (master)
//
// Optional build macro TX_AUTO_CSUM_EN: when defined, the last TX byte is
// replaced by the mod-256 sum of the preceding shadow bytes.
// -----------------------------------------------------------------------------
//   state    | meaning
//   T_IDLE   | waiting for tx_frame_start_i
//   T_GAP    | idle spacing before the next byte
//   T_START  | strobing the current byte into the UART TX core
//   T_WAIT   | waiting for tx_byte_done
//   R_HUNT0  | looking for SOF0
//   R_HUNT1  | SOF0 seen, expecting SOF1
//   R_DATA   | collecting payload and checksum
// -----------------------------------------------------------------------------
module frame_link_engine #(
    parameter int         TX_BYTES    = 32,
    parameter int         RX_BYTES    = 9,
    parameter logic [7:0] SOF0        = 8'h8E,
    parameter logic [7:0] SOF1        = 8'hAA,
    parameter int         GAP_CYC     = 6,
    parameter int         TIMEOUT_CYC = 50_000_000
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    tx_frame_start_i,
    input  logic [8*TX_BYTES-1:0]   tx_frame_i,
    output logic                    tx_busy_o,
    output logic                    tx_frame_sent_o,
    output logic [8*RX_BYTES-1:0]   rx_frame_o,
    output logic                    rx_frame_done_o,
    output logic                    check_sum_error_o,
    output logic                    com_no_response_o,
    output logic [7:0]              rx_err_cnt_o,
    frame_link_engine_if.master     byte_if
);

    localparam int TIW = (TX_BYTES > 1) ? $clog2(TX_BYTES) : 1;
    localparam int RIW = $clog2(RX_BYTES);
    localparam int GW  = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;
    localparam int TW  = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

    localparam logic [TIW-1:0] TX_LAST  = TIW'(TX_BYTES - 1);
    localparam logic [RIW-1:0] RX_LAST  = RIW'(RX_BYTES - 1);
    localparam logic [GW-1:0]  GAP_LAST = GW'((GAP_CYC > 0) ? GAP_CYC - 1 : 0);
    localparam logic [TW-1:0]  TO_LAST  = TW'(TIMEOUT_CYC - 1);
    localparam logic [7:0]     SOF_SUM  = SOF0 + SOF1;

    typedef enum logic [1:0] {T_IDLE, T_GAP, T_START, T_WAIT} tx_state_t;
    typedef enum logic [1:0] {R_HUNT0, R_HUNT1, R_DATA} rx_state_t;

    // ---------------------------------------------------------------- TX ----
    tx_state_t             tx_state_q, tx_state_d;
    logic [8*TX_BYTES-1:0] shadow_q, shadow_d;
    logic [TIW-1:0]        tx_idx_q, tx_idx_d;
    logic [GW-1:0]         gap_q, gap_d;
    logic [7:0]            tx_data_q, tx_data_d;
    logic                  tx_busy_q, tx_busy_d;
    logic                  tx_sent_q, tx_sent_d;
    logic [7:0]            cur_byte;
`ifdef TX_AUTO_CSUM_EN
    logic [7:0]            csum_q, csum_d;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            tx_state_q <= T_IDLE;
            shadow_q   <= '0;
            tx_idx_q   <= '0;
            gap_q      <= '0;
            tx_data_q  <= '0;
            tx_busy_q  <= 1'b0;
            tx_sent_q  <= 1'b0;
`ifdef TX_AUTO_CSUM_EN
            csum_q     <= '0;
`endif
        end else begin
            tx_state_q <= tx_state_d;
            shadow_q   <= shadow_d;
            tx_idx_q   <= tx_idx_d;
            gap_q      <= gap_d;
            tx_data_q  <= tx_data_d;
            tx_busy_q  <= tx_busy_d;
            tx_sent_q  <= tx_sent_d;
`ifdef TX_AUTO_CSUM_EN
            csum_q     <= csum_d;
`endif
        end
    end

    always_comb begin
        cur_byte = '0;
        for (int k = 0; k < TX_BYTES; k++) begin
            if (tx_idx_q == TIW'(k)) cur_byte = shadow_q[8*k +: 8];
        end
    end

    always_comb begin
        tx_state_d = tx_state_q;
        shadow_d   = shadow_q;
        tx_idx_d   = tx_idx_q;
        gap_d      = gap_q;
        tx_data_d  = tx_data_q;
        tx_busy_d  = tx_busy_q;
        tx_sent_d  = 1'b0;
`ifdef TX_AUTO_CSUM_EN
        csum_d     = csum_q;
`endif
        case (tx_state_q)
            T_IDLE: begin
                if (tx_frame_start_i) begin
                    shadow_d   = tx_frame_i;
                    tx_idx_d   = '0;
                    gap_d      = '0;
                    tx_busy_d  = 1'b1;
                    tx_state_d = T_GAP;
`ifdef TX_AUTO_CSUM_EN
                    csum_d     = '0;
`endif
                end
            end
            T_GAP: begin
                if (GAP_CYC == 0 || gap_q == GAP_LAST) begin
                    // Data is registered here so it is stable for the whole
                    // T_START strobe cycle and held until the next byte.
`ifdef TX_AUTO_CSUM_EN
                    tx_data_d = (tx_idx_q == TX_LAST) ? csum_q : cur_byte;
                    csum_d    = csum_q + cur_byte;
`else
                    tx_data_d = cur_byte;
`endif
                    tx_state_d = T_START;
                end else begin
                    gap_d = gap_q + 1'b1;
                end
            end
            T_START: begin
                tx_state_d = T_WAIT;
            end
            T_WAIT: begin
                if (byte_if.tx_byte_done) begin
                    if (tx_idx_q == TX_LAST) begin
                        tx_sent_d  = 1'b1;
                        tx_busy_d  = 1'b0;
                        tx_state_d = T_IDLE;
                    end else begin
                        tx_idx_d   = tx_idx_q + 1'b1;
                        gap_d      = '0;
                        tx_state_d = T_GAP;
                    end
                end
            end
            default: tx_state_d = T_IDLE;
        endcase
    end

    assign byte_if.tx_byte_data  = tx_data_q;
    assign byte_if.tx_byte_start = (tx_state_q == T_START);
    assign tx_busy_o             = tx_busy_q;
    assign tx_frame_sent_o       = tx_sent_q;

    // ---------------------------------------------------------------- RX ----
    rx_state_t               rx_state_q, rx_state_d;
    logic [RIW-1:0]          rx_idx_q, rx_idx_d;
    logic [7:0]              sum_q, sum_d;
    logic [8*RX_BYTES-9:0]   stage_q, stage_d;
    logic [8*RX_BYTES-1:0]   rx_frame_q, rx_frame_d;
    logic                    done_q, done_d;
    logic                    cserr_q, cserr_d;
    logic                    nores_q, nores_d;
    logic [TW-1:0]           to_cnt_q, to_cnt_d;
    logic [7:0]              err_cnt_q, err_cnt_d;
    logic                    timeout;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rx_state_q <= R_HUNT0;
            rx_idx_q   <= '0;
            sum_q      <= '0;
            stage_q    <= '0;
            rx_frame_q <= '0;
            done_q     <= 1'b0;
            cserr_q    <= 1'b0;
            nores_q    <= 1'b0;
            to_cnt_q   <= '0;
            err_cnt_q  <= '0;
        end else begin
            rx_state_q <= rx_state_d;
            rx_idx_q   <= rx_idx_d;
            sum_q      <= sum_d;
            stage_q    <= stage_d;
            rx_frame_q <= rx_frame_d;
            done_q     <= done_d;
            cserr_q    <= cserr_d;
            nores_q    <= nores_d;
            to_cnt_q   <= to_cnt_d;
            err_cnt_q  <= err_cnt_d;
        end
    end

    always_comb begin
        rx_state_d = rx_state_q;
        rx_idx_d   = rx_idx_q;
        sum_d      = sum_q;
        stage_d    = stage_q;
        rx_frame_d = rx_frame_q;
        done_d     = 1'b0;
        cserr_d    = 1'b0;
        nores_d    = 1'b0;
        to_cnt_d   = to_cnt_q;
        err_cnt_d  = err_cnt_q;
        timeout    = 1'b0;

        // Inter-byte timer; a byte arriving on the expiry cycle takes priority.
        if (rx_state_q != R_HUNT0 && !byte_if.rx_byte_valid) begin
            if (to_cnt_q == TO_LAST) timeout  = 1'b1;
            else                     to_cnt_d = to_cnt_q + 1'b1;
        end
        if (byte_if.rx_byte_valid) to_cnt_d = '0;

        case (rx_state_q)
            R_HUNT0: begin
                to_cnt_d = '0;
                if (byte_if.rx_byte_valid && byte_if.rx_byte_data == SOF0)
                    rx_state_d = R_HUNT1;
            end
            R_HUNT1: begin
                if (byte_if.rx_byte_valid) begin
                    if (byte_if.rx_byte_data == SOF1) begin
                        sum_d         = SOF_SUM;
                        rx_idx_d      = RIW'(2);
                        stage_d[15:0] = {SOF1, SOF0};
                        rx_state_d    = R_DATA;
                    end else if (byte_if.rx_byte_data != SOF0) begin
                        rx_state_d = R_HUNT0;
                    end
                end
            end
            R_DATA: begin
                if (byte_if.rx_byte_valid) begin
                    if (rx_idx_q == RX_LAST) begin
                        if (byte_if.rx_byte_data == sum_q) begin
                            rx_frame_d = {byte_if.rx_byte_data, stage_q};
                            done_d     = 1'b1;
                        end else begin
                            cserr_d = 1'b1;
                        end
                        rx_state_d = R_HUNT0;
                    end else begin
                        for (int k = 2; k < RX_BYTES - 1; k++) begin
                            if (rx_idx_q == RIW'(k)) stage_d[8*k +: 8] = byte_if.rx_byte_data;
                        end
                        sum_d    = sum_q + byte_if.rx_byte_data;
                        rx_idx_d = rx_idx_q + 1'b1;
                    end
                end
            end
            default: rx_state_d = R_HUNT0;
        endcase

        if (timeout) begin
            nores_d    = 1'b1;
            to_cnt_d   = '0;
            rx_state_d = R_HUNT0;
        end

        if ((cserr_d || nores_d) && err_cnt_q != 8'hFF)
            err_cnt_d = err_cnt_q + 8'd1;
    end

    assign rx_frame_o        = rx_frame_q;
    assign rx_frame_done_o   = done_q;
    assign check_sum_error_o = cserr_q;
    assign com_no_response_o = nores_q;
    assign rx_err_cnt_o      = err_cnt_q;

endmodule

// File: tb/tb_frame_link_engine.sv
module tb_frame_link_engine;
    localparam int TXB = 4;
    localparam int RXB = 9;
    localparam int GAP = 6;
    localparam int TO  = 100;

    logic              clk = 1'b0;
    logic              reset_n = 1'b0;
    logic              tx_frame_start_i = 1'b0;
    logic [8*TXB-1:0]  tx_frame_i = '0;
    logic              tx_busy_o;
    logic              tx_frame_sent_o;
    logic [8*RXB-1:0]  rx_frame_o;
    logic              rx_frame_done_o;
    logic              check_sum_error_o;
    logic              com_no_response_o;
    logic [7:0]        rx_err_cnt_o;

    frame_link_engine_if bif();

    frame_link_engine #(
        .TX_BYTES(TXB), .RX_BYTES(RXB), .SOF0(8'h8E), .SOF1(8'hAA),
        .GAP_CYC(GAP), .TIMEOUT_CYC(TO)
    ) dut (
        .clk               (clk),
        .reset_n           (reset_n),
        .tx_frame_start_i  (tx_frame_start_i),
        .tx_frame_i        (tx_frame_i),
        .tx_busy_o         (tx_busy_o),
        .tx_frame_sent_o   (tx_frame_sent_o),
        .rx_frame_o        (rx_frame_o),
        .rx_frame_done_o   (rx_frame_done_o),
        .check_sum_error_o (check_sum_error_o),
        .com_no_response_o (com_no_response_o),
        .rx_err_cnt_o      (rx_err_cnt_o),
        .byte_if           (bif)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Monitor / UART TX responder state (sampled 1 time unit after posedge)
    logic [7:0] sent_q[$];
    int         gap_q[$];
    int         gap_cnt = 0;
    int         start_run = 0, max_start_run = 0;
    int         resp_cnt = 0;
    bit         resp_en = 1'b0;
    int         cyc = 0;
    int         rx_done_cnt = 0, cserr_cnt = 0, nores_cnt = 0, sent_cnt = 0;
    int         last_valid_cyc = 0, last_nores_cyc = 0;
    int         last_done_cyc = 0, last_sent_cyc = 0;
    logic       prev_busy = 1'b0, busy_at_sent = 1'b0, busy_before_sent = 1'b0;

    always @(posedge clk) begin
        #1;
        cyc++;
        if (!reset_n) begin
            resp_cnt = 0;
            gap_cnt = 0;
            start_run = 0;
            bif.tx_byte_done = 1'b0;
        end else begin
            bif.tx_byte_done = 1'b0;
            if (bif.tx_byte_start) begin
                sent_q.push_back(bif.tx_byte_data);
                gap_q.push_back(gap_cnt);
                gap_cnt = 0;
                start_run++;
                if (start_run > max_start_run) max_start_run = start_run;
                if (resp_en) resp_cnt = 20;
            end else begin
                start_run = 0;
                if (resp_cnt > 0) begin
                    resp_cnt--;
                    if (resp_cnt == 0) begin
                        bif.tx_byte_done = 1'b1;
                        last_done_cyc = cyc;
                    end
                end
                if (bif.tx_byte_done || !tx_busy_o) gap_cnt = 0;
                else gap_cnt++;
            end
        end
        if (tx_frame_sent_o) begin
            sent_cnt++;
            last_sent_cyc = cyc;
            busy_at_sent = tx_busy_o;
            busy_before_sent = prev_busy;
        end
        prev_busy = tx_busy_o;
        if (rx_frame_done_o) rx_done_cnt++;
        if (check_sum_error_o) cserr_cnt++;
        if (com_no_response_o) begin
            nores_cnt++;
            last_nores_cyc = cyc;
        end
        if (bif.rx_byte_valid) last_valid_cyc = cyc;
    end

    // Runs from a negedge, leaves at a negedge; one idle cycle per byte.
    task automatic send_rx(input logic [7:0] b);
        bif.rx_byte_valid = 1'b1;
        bif.rx_byte_data  = b;
        @(negedge clk);
        bif.rx_byte_valid = 1'b0;
        @(negedge clk);
    endtask

    task automatic pulse_tx_start(input logic [8*TXB-1:0] f);
        tx_frame_i = f;
        tx_frame_start_i = 1'b1;
        @(negedge clk);
        tx_frame_start_i = 1'b0;
    endtask

    task automatic wait_sent(input int base, output bit ok);
        int n = 0;
        while (sent_cnt <= base && n < 400) begin
            @(negedge clk);
            n++;
        end
        ok = (sent_cnt > base);
    endtask

    task automatic wait_bytes(input int count, output bit ok);
        int n = 0;
        while (sent_q.size() < count && n < 200) begin
            @(negedge clk);
            n++;
        end
        ok = (sent_q.size() >= count);
    endtask

    task automatic test_reset;
        reset_n = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (tx_busy_o !== 1'b0) begin errors++; $display("FAIL reset_tx_busy: got %b want 0", tx_busy_o); end
        checks++; if (tx_frame_sent_o !== 1'b0) begin errors++; $display("FAIL reset_tx_sent: got %b want 0", tx_frame_sent_o); end
        checks++; if (bif.tx_byte_start !== 1'b0) begin errors++; $display("FAIL reset_tx_start: got %b want 0", bif.tx_byte_start); end
        checks++; if (bif.tx_byte_data !== 8'h00) begin errors++; $display("FAIL reset_tx_data: got %h want 00", bif.tx_byte_data); end
        checks++; if (rx_frame_o !== '0) begin errors++; $display("FAIL reset_rx_frame: got %h want 0", rx_frame_o); end
        checks++; if ({rx_frame_done_o, check_sum_error_o, com_no_response_o} !== 3'b000) begin errors++; $display("FAIL reset_rx_pulses: got %b want 000", {rx_frame_done_o, check_sum_error_o, com_no_response_o}); end
        checks++; if (rx_err_cnt_o !== 8'h00) begin errors++; $display("FAIL reset_err_cnt: got %0d want 0", rx_err_cnt_o); end
        reset_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_tx_basic;
        logic [31:0] f = 32'h44332211;
        bit ok;
        int base = sent_cnt;
        sent_q.delete(); gap_q.delete(); max_start_run = 0;
        resp_en = 1'b1;
        pulse_tx_start(f);
        checks++; if (tx_busy_o !== 1'b1) begin errors++; $display("FAIL tx_basic_busy: got %b want 1", tx_busy_o); end
        wait_sent(base, ok);
        checks++; if (!ok) begin errors++; $display("FAIL tx_basic_sent_timeout: sent pulses %0d want %0d", sent_cnt - base, 1); end
        checks++; if (sent_q.size() !== 4) begin errors++; $display("FAIL tx_basic_count: got %0d bytes want 4", sent_q.size()); end
        for (int i = 0; i < 4 && i < sent_q.size(); i++) begin
            checks++; if (sent_q[i] !== f[8*i +: 8]) begin errors++; $display("FAIL tx_basic_byte%0d: got %h want %h", i, sent_q[i], f[8*i +: 8]); end
            checks++; if (gap_q[i] < GAP) begin errors++; $display("FAIL tx_basic_gap%0d: got %0d idle cycles want >= %0d", i, gap_q[i], GAP); end
        end
        checks++; if (last_sent_cyc - last_done_cyc !== 1) begin errors++; $display("FAIL tx_basic_sent_latency: got %0d cycles want 1", last_sent_cyc - last_done_cyc); end
        checks++; if (busy_at_sent !== 1'b0 || busy_before_sent !== 1'b1) begin errors++; $display("FAIL tx_basic_busy_fall: got at/before %b%b want 01", busy_at_sent, busy_before_sent); end
        checks++; if (max_start_run !== 1) begin errors++; $display("FAIL tx_basic_start_width: got %0d cycles want 1", max_start_run); end
    endtask

    task automatic test_tx_busy_shadow;
        logic [31:0] exp;
        bit ok;
        int base = sent_cnt;
`ifdef TX_AUTO_CSUM_EN
        exp = 32'h06030201;
`else
        exp = 32'hFF030201;
`endif
        sent_q.delete(); gap_q.delete();
        pulse_tx_start(32'hFF030201);
        wait_bytes(2, ok);
        tx_frame_i = 32'hDEADBEEF;
        tx_frame_start_i = 1'b1;
        @(negedge clk);
        tx_frame_start_i = 1'b0;
        checks++; if (tx_busy_o !== 1'b1) begin errors++; $display("FAIL shadow_busy: got %b want 1", tx_busy_o); end
        wait_sent(base, ok);
        checks++; if (!ok) begin errors++; $display("FAIL shadow_sent_timeout: sent pulses %0d want 1", sent_cnt - base); end
        for (int i = 0; i < 4 && i < sent_q.size(); i++) begin
            checks++; if (sent_q[i] !== exp[8*i +: 8]) begin errors++; $display("FAIL shadow_byte%0d: got %h want %h", i, sent_q[i], exp[8*i +: 8]); end
        end
        repeat (40) @(negedge clk);
        checks++; if (sent_q.size() !== 4 || sent_cnt - base !== 1) begin errors++; $display("FAIL shadow_no_restart: got %0d bytes %0d frames want 4 1", sent_q.size(), sent_cnt - base); end
        checks++; if (tx_busy_o !== 1'b0) begin errors++; $display("FAIL shadow_idle: got busy %b want 0", tx_busy_o); end
    endtask

    task automatic test_rx_good;
        logic [7:0] seq [9] = '{8'h8E, 8'hAA, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h4D};
        int d0 = rx_done_cnt;
        int e0 = cserr_cnt;
        for (int i = 0; i < 9; i++) send_rx(seq[i]);
        checks++; if (rx_done_cnt - d0 !== 1) begin errors++; $display("FAIL rx_good_done: got %0d pulses want 1", rx_done_cnt - d0); end
        checks++; if (cserr_cnt - e0 !== 0) begin errors++; $display("FAIL rx_good_cserr: got %0d pulses want 0", cserr_cnt - e0); end
        checks++; if (rx_frame_o !== 72'h4D_06_05_04_03_02_01_AA_8E) begin errors++; $display("FAIL rx_good_frame: got %h want 4d060504030201aa8e", rx_frame_o); end
        checks++; if (rx_err_cnt_o !== 8'd0) begin errors++; $display("FAIL rx_good_errcnt: got %0d want 0", rx_err_cnt_o); end
    endtask

    task automatic test_rx_bad_resync;
        logic [7:0] seq [11] = '{8'h00, 8'h8E, 8'h8E, 8'hAA, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h4C};
        int d0 = rx_done_cnt;
        int e0 = cserr_cnt;
        for (int i = 0; i < 11; i++) send_rx(seq[i]);
        checks++; if (cserr_cnt - e0 !== 1) begin errors++; $display("FAIL rx_bad_cserr: got %0d pulses want 1", cserr_cnt - e0); end
        checks++; if (rx_done_cnt - d0 !== 0) begin errors++; $display("FAIL rx_bad_done: got %0d pulses want 0", rx_done_cnt - d0); end
        checks++; if (rx_frame_o !== 72'h4D_06_05_04_03_02_01_AA_8E) begin errors++; $display("FAIL rx_bad_frame_kept: got %h want 4d060504030201aa8e", rx_frame_o); end
        checks++; if (rx_err_cnt_o !== 8'd1) begin errors++; $display("FAIL rx_bad_errcnt: got %0d want 1", rx_err_cnt_o); end
    endtask

    task automatic test_timeout;
        logic [7:0] seq2 [9] = '{8'h8E, 8'hAA, 8'h10, 8'h20, 8'h30, 8'h40, 8'h50, 8'h60, 8'h88};
        logic [7:0] seq3 [8] = '{8'hAA, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h4D};
        int n0 = nores_cnt;
        int d0;
        int n = 0;
        send_rx(8'h8E); send_rx(8'hAA); send_rx(8'h01);
        while (nores_cnt == n0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        checks++; if (nores_cnt - n0 !== 1) begin errors++; $display("FAIL timeout_pulse: got %0d pulses want 1", nores_cnt - n0); end
        checks++; if (last_nores_cyc - last_valid_cyc !== TO) begin errors++; $display("FAIL timeout_latency: got %0d cycles want %0d", last_nores_cyc - last_valid_cyc, TO); end
        checks++; if (rx_err_cnt_o !== 8'd2) begin errors++; $display("FAIL timeout_errcnt: got %0d want 2", rx_err_cnt_o); end
        d0 = rx_done_cnt;
        for (int i = 0; i < 9; i++) send_rx(seq2[i]);
        checks++; if (rx_done_cnt - d0 !== 1) begin errors++; $display("FAIL timeout_recover_done: got %0d pulses want 1", rx_done_cnt - d0); end
        checks++; if (rx_frame_o !== 72'h88_60_50_40_30_20_10_AA_8E) begin errors++; $display("FAIL timeout_recover_frame: got %h want 8860504030201 0aa8e", rx_frame_o); end
        // Next byte lands exactly on the expiry cycle: the byte must win.
        n0 = nores_cnt;
        d0 = rx_done_cnt;
        send_rx(8'h8E);
        repeat (TO - 2) @(negedge clk);
        for (int i = 0; i < 8; i++) send_rx(seq3[i]);
        checks++; if (nores_cnt - n0 !== 0) begin errors++; $display("FAIL timeout_byte_wins: got %0d timeouts want 0", nores_cnt - n0); end
        checks++; if (rx_done_cnt - d0 !== 1) begin errors++; $display("FAIL timeout_byte_wins_done: got %0d pulses want 1", rx_done_cnt - d0); end
    endtask

    task automatic test_reset_mid;
        logic [7:0] seq [9] = '{8'h8E, 8'hAA, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h4D};
        logic [31:0] exp;
        bit ok;
        int base, d0;
`ifdef TX_AUTO_CSUM_EN
        exp = 32'h32776655;
`else
        exp = 32'h88776655;
`endif
        sent_q.delete(); gap_q.delete();
        pulse_tx_start(32'h44332211);
        wait_bytes(2, ok);
        for (int i = 0; i < 5; i++) send_rx(seq[i]);
        reset_n = 1'b0;
        repeat (2) @(negedge clk);
        checks++; if ({tx_busy_o, tx_frame_sent_o, bif.tx_byte_start} !== 3'b000) begin errors++; $display("FAIL midreset_tx_ctrl: got %b want 000", {tx_busy_o, tx_frame_sent_o, bif.tx_byte_start}); end
        checks++; if (bif.tx_byte_data !== 8'h00) begin errors++; $display("FAIL midreset_tx_data: got %h want 00", bif.tx_byte_data); end
        checks++; if (rx_frame_o !== '0 || rx_err_cnt_o !== 8'd0) begin errors++; $display("FAIL midreset_rx: got frame %h cnt %0d want 0 0", rx_frame_o, rx_err_cnt_o); end
        reset_n = 1'b1;
        @(negedge clk);
        d0 = rx_done_cnt;
        for (int i = 0; i < 9; i++) send_rx(seq[i]);
        checks++; if (rx_done_cnt - d0 !== 1 || rx_frame_o !== 72'h4D_06_05_04_03_02_01_AA_8E) begin errors++; $display("FAIL midreset_rx_fresh: got %0d pulses frame %h want 1 4d060504030201aa8e", rx_done_cnt - d0, rx_frame_o); end
        sent_q.delete(); gap_q.delete();
        base = sent_cnt;
        pulse_tx_start(32'h88776655);
        wait_sent(base, ok);
        checks++; if (!ok || sent_q.size() !== 4) begin errors++; $display("FAIL midreset_tx_fresh: got %0d bytes sent=%0d want 4 1", sent_q.size(), ok); end
        for (int i = 0; i < 4 && i < sent_q.size(); i++) begin
            checks++; if (sent_q[i] !== exp[8*i +: 8]) begin errors++; $display("FAIL midreset_tx_byte%0d: got %h want %h", i, sent_q[i], exp[8*i +: 8]); end
        end
    endtask

    task automatic test_err_saturation;
        for (int f = 0; f < 256; f++) begin
            send_rx(8'h8E); send_rx(8'hAA);
            for (int i = 0; i < 7; i++) send_rx(8'h00);
            if (f == 253) begin
                checks++; if (rx_err_cnt_o !== 8'd254) begin errors++; $display("FAIL errcnt_254: got %0d want 254", rx_err_cnt_o); end
            end
            if (f == 254) begin
                checks++; if (rx_err_cnt_o !== 8'd255) begin errors++; $display("FAIL errcnt_255: got %0d want 255", rx_err_cnt_o); end
            end
        end
        checks++; if (rx_err_cnt_o !== 8'd255) begin errors++; $display("FAIL errcnt_saturate: got %0d want 255", rx_err_cnt_o); end
    endtask

    initial begin
        bif.rx_byte_valid = 1'b0;
        bif.rx_byte_data  = 8'h00;
        @(negedge clk);
        test_reset();
        test_tx_basic();
        test_tx_busy_shadow();
        test_rx_good();
        test_rx_bad_resync();
        test_timeout();
        test_reset_mid();
        test_err_saturation();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, checks %0d errors %0d", checks, errors);
        $fatal(1, "watchdog");
    end

endmodule
